// File: rtl/enoc_input_unit.sv
// Router input unit: circular flit FIFO with head-of-line switch request.
// Dequeues when the switch grants the output port named by the head flit.
module enoc_input_unit #(
  parameter int M     = 5,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ce,
  input  logic [WIDTH-1:0]           i_data,
  input  logic [$clog2(M)-1:0]       i_dest,
  input  logic                       i_valid,
  output logic                       o_en,
  output logic [0:M-1]               o_output_req,
  input  logic [0:M-1]               i_output_grant,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int DESTW = $clog2(M);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int DW    = WIDTH + DESTW;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [DW-1:0]    head;
  logic [DESTW-1:0] head_dest;
  logic             nonempty;
  logic             grant_hit;
  logic             we;
  logic             deq;

  assign head      = mem_q[rd_ptr_q];
  assign head_dest = head[DESTW-1:0];
  assign nonempty  = (count_q != '0);

  assign o_en       = (count_q != CW'(DEPTH));
  assign o_data     = head[DW-1:DESTW];
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

  // Out-of-range destinations never request, so they can never be granted.
  always_comb begin
    o_output_req = '0;
    for (int i = 0; i < M; i++) begin
      o_output_req[i] = nonempty && (head_dest == DESTW'(i));
    end
  end

  assign grant_hit = |(o_output_req & i_output_grant);
  assign we        = ce & i_valid & o_en;
  assign deq       = ce & grant_hit;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (ce & i_valid & ~o_en);
    if (we) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({we, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_ptr_q] <= {i_data, i_dest};
    end
  end

endmodule

// File: tb/tb_enoc_input_unit.sv
// Randomized and directed bench for enoc_input_unit against a queue model.
// Model keeps flits in a queue; occupancy is simply the queue size.
module tb_enoc_input_unit;

  localparam int M = 5;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  ds;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        ce;
  logic [31:0] i_data;
  logic [2:0]  i_dest;
  logic        i_valid;
  logic        o_en;
  logic [0:4]  o_output_req;
  logic [0:4]  i_output_grant;
  logic [31:0] o_data;
  logic [2:0]  o_count;
  logic        o_overflow;

  int checks;
  int errors;

  ent_t mq[$];
  logic m_ovf;

  enoc_input_unit #(.M(M), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .ce(ce),
    .i_data(i_data),
    .i_dest(i_dest),
    .i_valid(i_valid),
    .o_en(o_en),
    .o_output_req(o_output_req),
    .i_output_grant(i_output_grant),
    .o_data(o_data),
    .o_count(o_count),
    .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:4] onehot(input logic [2:0] d);
    logic [0:4] r;
    r = '0;
    if (d < 3'd5) r[d] = 1'b1;
    return r;
  endfunction

  function automatic logic [0:4] head_grant();
    if (mq.size() == 0) return '0;
    return onehot(mq[0].ds);
  endfunction

  task automatic check_outputs(input string tag);
    logic [0:4] er;
    er = head_grant();
    chk({tag, ".en"}, 64'(o_en), 64'(mq.size() != DEPTH));
    chk({tag, ".req"}, 64'(o_output_req), 64'(er));
    chk({tag, ".cnt"}, 64'(o_count), 64'(mq.size()));
    chk({tag, ".ovf"}, 64'(o_overflow), 64'(m_ovf));
    if (mq.size() != 0)
      chk({tag, ".data"}, 64'(o_data), 64'(mq[0].d));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input string tag, input logic c, input logic v,
                      input logic [31:0] d, input logic [2:0] ds,
                      input logic [0:4] g);
    bit full, do_deq, do_wr;
    ce = c;
    i_valid = v;
    i_data = d;
    i_dest = ds;
    i_output_grant = g;
    #1;
    check_outputs(tag);
    @(posedge clk);
    full = (mq.size() == DEPTH);
    do_wr = c && v && !full;
    do_deq = c && mq.size() > 0 && ((g & head_grant()) != '0);
    if (c && v && full) m_ovf = 1'b1;
    if (do_deq) void'(mq.pop_front());
    if (do_wr) mq.push_back('{d: d, ds: ds});
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b1, 1'b0, 32'h0, 3'd0, 5'b00000);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_ovf = 1'b0;
    reset = 1'b1;
    ce = 1'b1;
    i_valid = 1'b0;
    i_data = '0;
    i_dest = '0;
    i_output_grant = '0;
    #2;
    chk("rst.en", 64'(o_en), 64'd1);
    chk("rst.req", 64'(o_output_req), 64'd0);
    chk("rst.cnt", 64'(o_count), 64'd0);
    chk("rst.ovf", 64'(o_overflow), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single flit held until its own grant.
    step("s1.wr", 1'b1, 1'b1, 32'hA5, 3'd2, 5'b00000);
    step("s1.hold", 1'b1, 1'b0, 32'h0, 3'd0, 5'b00000);
    chk("s1.req", 64'(o_output_req), 64'(5'b00100));
    chk("s1.data", 64'(o_data), 64'hA5);
    step("s1.gnt", 1'b1, 1'b0, 32'h0, 3'd0, 5'b00100);
    chk("s1.cnt0", 64'(o_count), 64'd0);
    idle("s1.after");

    // Grant for the wrong port is ignored.
    step("mm.wr", 1'b1, 1'b1, 32'h33, 3'd3, 5'b00000);
    step("mm.bad", 1'b1, 1'b0, 32'h0, 3'd0, 5'b01000);
    chk("mm.cnt", 64'(o_count), 64'd1);
    step("mm.good", 1'b1, 1'b0, 32'h0, 3'd0, 5'b00010);
    chk("mm.cnt0", 64'(o_count), 64'd0);

    // Stream across pointer wrap with matching grants.
    for (int i = 0; i < 6; i++)
      step("wrap.wr", 1'b1, 1'b1, 32'h100 + i, 3'(i % 5), head_grant());
    for (int i = 0; i < 8; i++)
      step("wrap.drain", 1'b1, 1'b0, 32'h0, 3'd0, head_grant());
    chk("wrap.cnt0", 64'(o_count), 64'd0);

    // Fill then overflow.
    for (int i = 0; i < 4; i++)
      step("fill.wr", 1'b1, 1'b1, 32'h200 + i, 3'(i), 5'b00000);
    chk("fill.cnt", 64'(o_count), 64'd4);
    chk("fill.en", 64'(o_en), 64'd0);
    step("fill.ovf", 1'b1, 1'b1, 32'hDEAD, 3'd4, 5'b00000);
    chk("fill.ovf1", 64'(o_overflow), 64'd1);
    chk("fill.cnt4", 64'(o_count), 64'd4);
    chk("fill.head", 64'(o_data), 64'h200);
    // Full blocks a write even when a dequeue happens the same cycle.
    step("fill.wrdq", 1'b1, 1'b1, 32'hBEEF, 3'd1, head_grant());
    chk("fill.cnt3", 64'(o_count), 64'd3);

    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    #1;
    chk("ar.cnt", 64'(o_count), 64'd0);
    chk("ar.ovf", 64'(o_overflow), 64'd0);
    chk("ar.en", 64'(o_en), 64'd1);
    chk("ar.req", 64'(o_output_req), 64'd0);
    mq.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step("ar.wr", 1'b1, 1'b1, 32'h77, 3'd0, 5'b00000);
    idle("ar.chk");

    // Clock-enable gating.
    void'(mq.size());
    step("ce.wr", 1'b1, 1'b1, 32'h300, 3'd1, 5'b00000);
    chk("ce.cnt2", 64'(o_count), 64'd2);
    for (int i = 0; i < 3; i++)
      step("ce.off", 1'b0, 1'b1, 32'h999, 3'd2, head_grant());
    chk("ce.hold", 64'(o_count), 64'd2);
    chk("ce.noovf", 64'(o_overflow), 64'd0);
    step("ce.on", 1'b1, 1'b0, 32'h0, 3'd0, head_grant());
    chk("ce.resume", 64'(o_count), 64'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic c, v;
      logic [0:4] g;
      c = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) g = head_grant();
      else g = 5'($urandom);
      step("rnd", c, v, $urandom, 3'($urandom_range(0, 4)), g);
    end
    idle("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
